// File: rtl/core_dmem_bridge.sv
// core_dmem_bridge: turns a single-cycle core load/store request into a
// request/grant/response bus transaction, stalling the core until the
// response arrives or the access times out.
module core_dmem_bridge #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  // core side
  input  logic                      core_req_i,
  input  logic                      core_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0]     core_wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] core_be_i,
  output logic [DATA_WIDTH-1:0]     core_rdata_o,
  output logic                      core_stall_o,
  // bus side
  output logic                      bus_req_o,
  output logic                      bus_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0]     bus_wdata_o,
  output logic [TRANSFER_WIDTH-1:0] bus_be_o,
  input  logic                      bus_gnt_i,
  input  logic                      bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     bus_rdata_i,
  // status
  output logic                      err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Transfer fields captured from the core when an access starts.
  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [TRANSFER_WIDTH-1:0] be;
  } xfer_t;

  // Last bus cycle an access may spend before it is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  xfer_t                 xfer;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [7:0]            tmo_cnt;
  logic                  err_q;

  logic                  start;    // IDLE accepting a new core access
  logic                  busy;     // bus transaction outstanding
  logic                  cmpl;     // response completes the access this cycle
  logic                  tmo_hit;  // bus-cycle budget exhausted without response

  // Qualify bus handshakes by state; anything seen in IDLE/DONE is dropped.
  always_comb begin
    start   = (state == IDLE) && core_req_i;
    busy    = (state == REQ) || (state == WAIT);
    cmpl    = ((state == REQ)  && bus_gnt_i && bus_rvalid_i) ||
              ((state == WAIT) && bus_rvalid_i);
    // completion wins over timeout when both land in the same cycle
    tmo_hit = busy && !cmpl && (tmo_cnt == TMO_LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (core_req_i) state_nxt = REQ;
      REQ: begin
        if (cmpl || tmo_hit)  state_nxt = DONE;
        else if (bus_gnt_i)   state_nxt = WAIT;
      end
      WAIT: if (cmpl || tmo_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; stall covers the request cycle in IDLE too,
  // so the core never advances past an access that has not finished.
  always_comb begin
    bus_req_o    = (state == REQ);
    core_stall_o = start || busy;
  end

  // Transfer latch, timeout counter, read register and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer    <= '0;
      tmo_cnt <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (start) begin
        xfer    <= '{we: core_we_i, addr: core_addr_i,
                     wdata: core_wdata_i, be: core_be_i};
        tmo_cnt <= '0;
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      // stores leave the read register alone; an abort reads as zero
      if (cmpl && !xfer.we) rd_q <= bus_rdata_i;
      if (tmo_hit) begin
        rd_q  <= '0;
        err_q <= 1'b1;
      end
    end
  end

  assign bus_we_o     = xfer.we;
  assign bus_addr_o   = xfer.addr;
  assign bus_wdata_o  = xfer.wdata;
  assign bus_be_o     = xfer.be;
  assign core_rdata_o = rd_q;
  assign err_o        = err_q;

endmodule
